gf128_reduce_fifo: RTL and testbench
====================================

# gf128_reduce_fifo

Consumer for the 256-bit carry-less product stream of the GHASH multiplier. The block reduces each product modulo the GCM field polynomial P(x) = x^128 + x^7 + x^2 + x + 1 in a two-stage pipeline. It buffers the 128-bit field elements in a FWFT FIFO so the GHASH accumulator can apply valid/ready backpressure. The multiplier has no stall input, so this block absorbs its valid-only output and flags any loss.

## Interface
- WIDTH, 128: field element width. 128 is the only legal value because the polynomial is fixed.
- DEPTH, 4: output FIFO entries. Power of two, at least 2.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  product valid. Sampled every cycle; there is no ready.
- product_i  in  2*WIDTH  carry-less product, normal order (bit i = coefficient of x^i)
- valid_o  out  1  FIFO head valid
- ready_i  in  1  downstream accepts the head
- result_o  out  WIDTH  reduced field element at the FIFO head
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky flag: at least one product was dropped

## Operation
- Split the product: h = product_i[255:128], l = product_i[127:0].
- Stage 1 (registered s1, plus 7-bit o1):
  - t = h ^ (h<<1) ^ (h<<2) ^ (h<<7), computed at 135 bits.
  - s1 = l ^ t[127:0].
  - o1 = t[134:128].
- Stage 2 (registered s2):
  - s2 = s1 ^ o1 ^ (o1<<1) ^ (o1<<2) ^ (o1<<7), with o1 zero-extended to 128 bits.
  - No third fold is needed because the shifted terms span at most 14 bits.
- Each pipeline stage carries a valid bit (v1, v2). Data registers load only when the incoming valid is 1; valid bits load every cycle.
- FIFO:
  - Write pointer, read pointer and a count, each with one extra bit.
  - push = v2; pop = valid_o & ready_i.
  - valid_o = (count != 0).
  - result_o = mem[rd_ptr], fall-through, no output register.
- Boundary rules:
  - push with count == DEPTH and no pop: the entry is dropped, overflow_o is set, and pointers and count are unchanged.
  - push and pop in the same cycle when full: both happen, count stays DEPTH, no overflow.
  - push and pop in the same cycle when empty: not possible, since valid_o = 0. The push lands and count becomes 1.
  - Pointers wrap modulo DEPTH.
  - overflow_o clears only on rst.
- Reset (synchronous, rst = 1 at a clk edge):
  - v1, v2, pointers and count go to 0; overflow_o goes to 0.
  - Data registers and FIFO memory are not reset.
  - Outputs after reset: valid_o = 0, level_o = 0, overflow_o = 0. result_o is don't-care while valid_o = 0.
  - Reset during operation discards all in-flight and buffered results. valid_i sampled on the reset edge is ignored.

## Timing
- valid_i sampled at edge N: v1 is set at N, v2 at N+1, and the FIFO push happens at edge N+2.
- With the FIFO empty, valid_o rises in the cycle after edge N+2. Latency is 3 cycles from the sampling edge.
- Throughput: one product per cycle, sustained, while ready_i = 1.
- Order is preserved: results leave in the order their products were sampled.
- level_o reflects buffered entries only, not the 2 in flight. To avoid loss, the upstream must limit outstanding products to DEPTH - level_o - 2.
- overflow_o rises in the cycle after the dropping edge.

## Test plan
- Product {128'h0, 128'h1234...cdef} → result_o = 128'h1234...cdef, valid_o high exactly 3 cycles after valid_i.
- Product 256'h1 << 128 (x^128) → result_o = 128'h87.
- Product 256'h1 << 255 (x^255) → result_o = 128'h8000_0000_0000_0000_0000_0000_0000_2049.
- DEPTH = 4, ready_i = 0, 6 back-to-back products:
  - level_o reaches 4 and overflow_o = 1.
  - After raising ready_i, exactly the first 4 results are drained, in order.
  - overflow_o stays 1.
- FIFO full, ready_i = 1 and valid_i = 1 every cycle for 20 cycles → level_o stays 4, overflow_o stays 0, and all 20 results are correct and in order.
- Assert rst for 1 cycle with 2 products in flight and 3 buffered:
  - The next cycle shows valid_o = 0, level_o = 0, overflow_o = 0.
  - No stale result ever appears.
  - A product sent after reset emerges correctly with 3-cycle latency.

Source files
------------

// File: rtl/gf128_reduce_fifo.sv
// Reduces 256-bit carry-less products modulo x^128 + x^7 + x^2 + x + 1 in two
// pipeline stages and buffers the field elements in a first-word-fall-through FIFO.
module gf128_reduce_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [2*WIDTH-1:0]       product_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         result_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = WIDTH + 7;

    logic [WIDTH-1:0] h_c;
    logic [WIDTH-1:0] l_c;
    logic [TW-1:0]    t_c;
    logic [WIDTH-1:0] o1_ext_c;
    logic [WIDTH-1:0] fold_c;

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] s1;
    logic [6:0]       o1;
    logic [WIDTH-1:0] s2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    // First fold: x^128 == x^7 + x^2 + x + 1, leaving a 7-bit overhang.
    always_comb begin
        h_c      = product_i[2*WIDTH-1:WIDTH];
        l_c      = product_i[WIDTH-1:0];
        t_c      = TW'(h_c) ^ (TW'(h_c) << 1) ^ (TW'(h_c) << 2) ^ (TW'(h_c) << 7);
        o1_ext_c = WIDTH'(o1);
        fold_c   = o1_ext_c ^ (o1_ext_c << 1) ^ (o1_ext_c << 2) ^ (o1_ext_c << 7);
    end

    // Pipeline valids are reset; data registers only load behind a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= valid_i;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) begin
            s1 <= l_c ^ t_c[WIDTH-1:0];
            o1 <= t_c[TW-1:WIDTH];
        end
        if (v1) begin
            s2 <= s1 ^ fold_c;
        end
    end

    // A push into a full FIFO only lands when the head leaves on the same edge.
    always_comb begin
        full_c = (count == PW'(DEPTH));
        pop_c  = valid_o & ready_i;
        push_c = v2 & (~full_c | pop_c);
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + PW'(1);
            end else if (pop_c && !push_c) begin
                count <= count - PW'(1);
            end
            if (v2 && !push_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign valid_o  = (count != '0);
    assign result_o = mem[rd_ptr[AW-1:0]];
    assign level_o  = count;

endmodule

// File: tb/tb_gf128_reduce_fifo.sv
// Directed bench for gf128_reduce_fifo: hand-computed reductions, latency,
// overflow, full-FIFO streaming and mid-stream reset.
module tb_gf128_reduce_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [255:0] product_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] result_o;
    logic [2:0]   level_o;
    logic         overflow_o;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q [$];

    gf128_reduce_fifo #(.WIDTH(128), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .product_i  (product_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: schoolbook long division by P(x), top bit first.
    function automatic logic [127:0] ref_reduce(input logic [255:0] p);
        logic [255:0] a;
        logic [255:0] poly;
        a    = p;
        poly = (256'd1 << 128) | 256'h87;
        for (int i = 255; i >= 128; i--) begin
            if (a[i]) a = a ^ (poly << (i - 128));
        end
        return a[127:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive inputs, score the head if it leaves on this edge, sample #1 after.
    task automatic cyc(input logic v, input logic [255:0] p, input logic r);
        valid_i   = v;
        product_i = p;
        ready_i   = r;
        if (r && valid_o) begin
            if (exp_q.size() == 0) chk("spurious_out", 128'(valid_o), 128'd0);
            else                   chk("drain_data", result_o, exp_q.pop_front());
        end
        if (v) exp_q.push_back(ref_reduce(p));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst       = 1'b1;
        valid_i   = 1'b1;
        product_i = rnd256();
        ready_i   = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic single(input string tag, input logic [255:0] p, input logic [127:0] hand);
        cyc(1'b1, p, 1'b0);
        chk({tag, "_v_n"}, 128'(valid_o), 128'd0);
        cyc(1'b0, '0, 1'b0);
        chk({tag, "_v_n1"}, 128'(valid_o), 128'd0);
        cyc(1'b0, '0, 1'b0);
        chk({tag, "_v_n2"}, 128'(valid_o), 128'd1);
        chk({tag, "_data"}, result_o, hand);
        cyc(1'b0, '0, 1'b1);
        chk({tag, "_empty"}, 128'(valid_o), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        valid_i   = 1'b0;
        product_i = '0;
        ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 128'(valid_o), 128'd0);
        chk("rst_level", 128'(level_o), 128'd0);
        chk("rst_ovf",   128'(overflow_o), 128'd0);

        single("lo_pass", {128'h0, 128'h0123456789abcdef0123456789abcdef},
               128'h0123456789abcdef0123456789abcdef);
        single("x128", 256'd1 << 128, 128'h87);
        single("x255", 256'd1 << 255, 128'h8000_0000_0000_0000_0000_0000_0000_2049);

        // Six back-to-back products into a stalled FIFO: the last two are dropped.
        for (int k = 0; k < 6; k++) cyc(1'b1, rnd256(), 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("ovf_level", 128'(level_o), 128'd4);
        chk("ovf_flag",  128'(overflow_o), 128'd1);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_head_valid", 128'(valid_o), 128'd1);
            cyc(1'b0, '0, 1'b1);
        end
        chk("ovf_drained", 128'(valid_o), 128'd0);
        chk("ovf_sticky",  128'(overflow_o), 128'd1);

        // Full FIFO streaming at one per cycle with simultaneous push and pop.
        pulse_reset();
        chk("rst2_ovf", 128'(overflow_o), 128'd0);
        for (int k = 0; k < 4; k++) cyc(1'b1, rnd256(), 1'b0);
        cyc(1'b1, rnd256(), 1'b0);
        cyc(1'b1, rnd256(), 1'b0);
        chk("full_level", 128'(level_o), 128'd4);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, rnd256(), 1'b1);
            chk("stream_level", 128'(level_o), 128'd4);
            chk("stream_ovf",   128'(overflow_o), 128'd0);
        end
        for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1);
        chk("stream_left", 128'(exp_q.size()), 128'd0);
        chk("stream_empty", 128'(valid_o), 128'd0);

        // Reset with three buffered and two in flight.
        for (int k = 0; k < 5; k++) cyc(1'b1, rnd256(), 1'b0);
        chk("pre_rst_level", 128'(level_o), 128'd3);
        pulse_reset();
        chk("mid_rst_valid", 128'(valid_o), 128'd0);
        chk("mid_rst_level", 128'(level_o), 128'd0);
        chk("mid_rst_ovf",   128'(overflow_o), 128'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b1);
            chk("no_stale", 128'(valid_o), 128'd0);
        end
        single("post_rst", {128'h0000_0000_0000_0000_0000_0000_0000_0001,
                            128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978},
               128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_69ff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
